// File: rtl/control_fsm_if.sv
// ---------------------------------------------------------------------------
// control_fsm_if -- bundle between the multicycle control FSM and datapath.
//
// Parameter:
//   COUNT_W      width of the retired-instruction counter
//
// Signals (direction given from the FSM's side, modport "slave"):
//   opCode       in   6  instruction bits [31:26]
//   zero         in   1  ALU zero flag
//   PCWriteCond  out  1  conditional PC write (always 0)
//   PCWrite      out  1  PC load enable
//   IorD         out  1  memory address select (0 = PC, 1 = ALU result)
//   MemRead      out  1  memory read strobe
//   MemWrite     out  1  memory write enable
//   MemtoReg     out  1  register write data select (1 = memory)
//   IRWrite      out  1  instruction register load
//   PCSource     out  2  PC source select
//   ALUOp        out  2  ALU decoder mode
//   ALUSrcB      out  2  ALU B operand select
//   ALUSrcA      out  1  ALU A operand select
//   RegWrite     out  1  register file write enable
//   RegDst       out  1  destination register select (0 = rt, 1 = rd)
//   state        out  4  current FSM state, for debug
//   illegal_op   out  1  unsupported opCode seen in DECODE
//   instr_count  out  COUNT_W  completed-instruction counter
//
// Timing contract: there is no valid/ready pair on this bundle. The datapath
// must hold opCode stable from IRLOAD through DECODE and present zero during
// BR_CMP; every control output is valid for the whole cycle in which the FSM
// sits in the corresponding state.
// ---------------------------------------------------------------------------
interface control_fsm_if #(
  parameter int COUNT_W = 16
);
  logic [5:0]         opCode;
  logic               zero;
  logic               PCWriteCond;
  logic               PCWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               IRWrite;
  logic [1:0]         PCSource;
  logic [1:0]         ALUOp;
  logic [1:0]         ALUSrcB;
  logic               ALUSrcA;
  logic               RegWrite;
  logic               RegDst;
  logic [3:0]         state;
  logic               illegal_op;
  logic [COUNT_W-1:0] instr_count;

  // Datapath side
  modport master (
    output opCode, zero,
    input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    input  PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst,
    input  state, illegal_op, instr_count
  );

  // Control FSM side
  modport slave (
    input  opCode, zero,
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    output PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst,
    output state, illegal_op, instr_count
  );
endinterface

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm -- Moore control unit for a multicycle MIPS-like datapath.
//
// Ports:
//   clk    in  rising-edge clock shared with the datapath
//   reset  in  synchronous, active-high reset
//   bus    control_fsm_if.slave: opCode/zero in, control strobes, debug
//          state, illegal_op and instr_count out
//
// Supported opCodes: R-type (000000), lw (100011), sw (101011),
// beq (000100), j (000010). addi (001000) is supported only when the
// macro CTRL_ADDI_EN is defined; otherwise it is reported as illegal.
//
// All control outputs are decoded from the state register alone and are
// forced to 0 while reset is high so that an instruction interrupted by
// reset cannot write memory or registers in the reset cycle.
// ---------------------------------------------------------------------------
module control_fsm #(
  parameter int COUNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  control_fsm_if.slave bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_IRLOAD  = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_LW_ADDR = 4'd3;
  localparam logic [3:0] S_LW_WB   = 4'd4;
  localparam logic [3:0] S_SW      = 4'd5;
  localparam logic [3:0] S_R_WB    = 4'd6;
  localparam logic [3:0] S_ADDI_WB = 4'd7;
  localparam logic [3:0] S_BR_CMP  = 4'd8;
  localparam logic [3:0] S_BR_TGT  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]         state_q, state_d;
  logic               take_q, take_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               op_legal;
  logic               is_terminal;

  logic       pc_write, ior_d, mem_read, mem_write, mem_to_reg, ir_write;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, illegal;

  // Next-state, branch-take and retired-instruction counter.
  always_comb begin
    state_d     = S_FETCH;
    take_d      = take_q;
    count_d     = count_q;
    op_legal    = 1'b1;
    is_terminal = 1'b0;

    case (state_q)
      S_FETCH:   state_d = S_IRLOAD;
      S_IRLOAD:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opCode)
          OP_RTYPE: state_d = S_R_WB;
          OP_LW:    state_d = S_LW_ADDR;
          OP_SW:    state_d = S_SW;
          OP_BEQ:   state_d = S_BR_CMP;
          OP_J:     state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:  state_d = S_ADDI_WB;
`endif
          default: begin
            state_d  = S_FETCH;
            op_legal = 1'b0;
          end
        endcase
      end
      S_LW_ADDR: state_d = S_LW_WB;
      S_BR_CMP: begin
        take_d  = bus.zero;
        state_d = S_BR_TGT;
      end
      S_LW_WB, S_SW, S_R_WB, S_BR_TGT, S_JUMP: begin
        state_d     = S_FETCH;
        is_terminal = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      S_ADDI_WB: begin
        state_d     = S_FETCH;
        is_terminal = 1'b1;
      end
`endif
      // Unused codes (and ADDI_WB when addi is compiled out) recover to
      // FETCH without retiring anything.
      default:   state_d = S_FETCH;
    endcase

    // An illegal opCode retires as a 3-cycle no-op; terminal states retire
    // their instruction on the way back to FETCH.
    if ((state_q == S_DECODE && !op_legal) || is_terminal) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Moore output decode.
  always_comb begin
    pc_write   = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    ir_write   = 1'b0;
    pc_source  = 2'b00;
    alu_op     = 2'b00;
    alu_src_b  = 2'b00;
    alu_src_a  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_IRLOAD:  ir_write = 1'b1;
      S_DECODE:  illegal = !op_legal;
      S_LW_ADDR: begin
        mem_read  = 1'b1;
        ior_d     = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_LW_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_SW: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_R_WB: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      S_ADDI_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        reg_write = 1'b1;
      end
`endif
      S_BR_CMP: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
      end
      S_BR_TGT: begin
        alu_src_b = 2'b11;
        pc_source = 2'b01;
        pc_write  = take_q;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      ior_d      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      ir_write   = 1'b0;
      pc_source  = 2'b00;
      alu_op     = 2'b00;
      alu_src_b  = 2'b00;
      alu_src_a  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      take_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      take_q  <= take_d;
      count_q <= count_d;
    end
  end

  assign bus.PCWriteCond = 1'b0;
  assign bus.PCWrite     = pc_write;
  assign bus.IorD        = ior_d;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.IRWrite     = ir_write;
  assign bus.PCSource    = pc_source;
  assign bus.ALUOp       = alu_op;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.RegWrite    = reg_write;
  assign bus.RegDst      = reg_dst;
  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal;
  assign bus.instr_count = count_q;

endmodule
